// File: rtl/bon_pattern_server.sv
// Responder for the BON en/addr/data/flag interface: serves stored pattern words,
// scores per-address flags against expected bits and judges the final result.
module bon_pattern_server #(
    parameter int unsigned DATA_W   = 10,
    parameter int unsigned ADDR_W   = 10,
    parameter int unsigned MAX_ADDR = 1023,
    parameter int unsigned TMO_W    = 24
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_load_en,
    input  logic [ADDR_W-1:0] i_load_addr,
    input  logic [DATA_W:0]   i_load_data,
    input  logic              i_ans_en,
    input  logic [DATA_W-1:0] i_ans_data,
    input  logic              i_go,
    output logic              o_start,
    input  logic              i_en,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic              i_flag,
    input  logic              i_fin,
    input  logic [DATA_W-1:0] i_result,
    output logic [DATA_W-1:0] o_data,
    output logic              o_done,
    output logic              o_pass,
    output logic              o_timeout,
    output logic [ADDR_W:0]   o_wrong_cnt,
    output logic [ADDR_W:0]   o_get_cnt
);

    localparam int unsigned CNT_W = ADDR_W + 1;
    localparam int unsigned DEPTH = MAX_ADDR + 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_next;

    logic [DATA_W:0]     r_mem [DEPTH];
    logic [DATA_W-1:0]   r_ans;
    logic [TMO_W-1:0]    r_timer;
    logic [CNT_W-1:0]    r_wrong_cnt;
    logic [CNT_W-1:0]    r_get_cnt;
    logic                r_start;
    logic                r_done;
    logic                r_pass;
    logic                r_timeout;

    logic                w_in_run;
    logic                w_addr_ok;
    logic                w_load_addr_ok;
    logic                w_load_ok;
    logic                w_hit;
    logic [DATA_W:0]     w_entry;
    logic                w_mismatch;
    logic                w_good;
    logic                w_timer_max;
    logic [CNT_W-1:0]    w_wrong_inc;
    logic [CNT_W-1:0]    w_get_inc;

    logic [TMO_W-1:0]    w_timer_d;
    logic [CNT_W-1:0]    w_wrong_d;
    logic [CNT_W-1:0]    w_get_d;
    logic                w_start_d;
    logic                w_done_d;
    logic                w_pass_d;
    logic                w_timeout_d;

    // Widened compares keep the range check meaningful when MAX_ADDR fills the address space
    assign w_in_run       = (r_state == S_RUN);
    assign w_addr_ok      = ({1'b0, i_addr} <= (ADDR_W+1)'(MAX_ADDR));
    assign w_load_addr_ok = ({1'b0, i_load_addr} <= (ADDR_W+1)'(MAX_ADDR));
    assign w_load_ok      = i_load_en && !w_in_run && w_load_addr_ok;
    assign w_hit          = i_en && w_in_run && w_addr_ok;
    assign w_entry        = r_mem[i_addr];
    assign w_mismatch     = w_hit && (i_flag != w_entry[0]);
    assign w_good         = w_hit && !w_mismatch && i_flag;
    assign w_timer_max    = &r_timer;

    assign w_wrong_inc = (w_mismatch && (r_wrong_cnt != '1)) ? r_wrong_cnt + CNT_W'(1) : r_wrong_cnt;
    assign w_get_inc   = (w_good && (r_get_cnt != '1)) ? r_get_cnt + CNT_W'(1) : r_get_cnt;

    // Served word is combinational so the requester can derive flag in the same cycle
    assign o_data = w_hit ? w_entry[DATA_W:1] : '0;

    // Pattern memory: not cleared by reset, writable only outside a run
    always_ff @(posedge i_clk) begin
        if (w_load_ok) begin
            r_mem[i_load_addr] <= i_load_data;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_ans <= '0;
        end else if (i_ans_en && !w_in_run) begin
            r_ans <= i_ans_data;
        end
    end

    // State register
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic; fin takes priority over an expiring timer
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE, S_DONE: begin
                if (i_go) begin
                    w_state_next = S_RUN;
                end
            end
            S_RUN: begin
                if (i_fin || w_timer_max) begin
                    w_state_next = S_DONE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // Output/datapath next values
    always_comb begin
        w_timer_d   = r_timer;
        w_wrong_d   = r_wrong_cnt;
        w_get_d     = r_get_cnt;
        w_start_d   = r_start;
        w_done_d    = r_done;
        w_pass_d    = r_pass;
        w_timeout_d = r_timeout;
        case (r_state)
            S_IDLE, S_DONE: begin
                if (i_go) begin
                    w_timer_d   = '0;
                    w_wrong_d   = '0;
                    w_get_d     = '0;
                    w_start_d   = 1'b1;
                    w_done_d    = 1'b0;
                    w_pass_d    = 1'b0;
                    w_timeout_d = 1'b0;
                end
            end
            S_RUN: begin
                w_wrong_d = w_wrong_inc;
                w_get_d   = w_get_inc;
                w_timer_d = w_timer_max ? r_timer : r_timer + TMO_W'(1);
                if (i_fin) begin
                    w_start_d = 1'b0;
                    w_done_d  = 1'b1;
                    w_pass_d  = (i_result == r_ans) && (w_wrong_inc == '0);
                end else if (w_timer_max) begin
                    w_start_d   = 1'b0;
                    w_done_d    = 1'b1;
                    w_pass_d    = 1'b0;
                    w_timeout_d = 1'b1;
                end
            end
            default: begin
                w_start_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_timer     <= '0;
            r_wrong_cnt <= '0;
            r_get_cnt   <= '0;
            r_start     <= 1'b0;
            r_done      <= 1'b0;
            r_pass      <= 1'b0;
            r_timeout   <= 1'b0;
        end else begin
            r_timer     <= w_timer_d;
            r_wrong_cnt <= w_wrong_d;
            r_get_cnt   <= w_get_d;
            r_start     <= w_start_d;
            r_done      <= w_done_d;
            r_pass      <= w_pass_d;
            r_timeout   <= w_timeout_d;
        end
    end

    assign o_start     = r_start;
    assign o_done      = r_done;
    assign o_pass      = r_pass;
    assign o_timeout   = r_timeout;
    assign o_wrong_cnt = r_wrong_cnt;
    assign o_get_cnt   = r_get_cnt;

endmodule

// File: tb/tb_bon_pattern_server.sv
// Directed bench for bon_pattern_server: a requester model drives reads, served words
// are scored through an expectation queue, and verdicts are checked against a bench model.
module tb_bon_pattern_server;

    logic        clk;
    logic        rst;
    logic        load_en;
    logic [9:0]  load_addr;
    logic [10:0] load_data;
    logic        ans_en;
    logic [9:0]  ans_data;
    logic        go;
    logic        start;
    logic        en;
    logic [9:0]  addr;
    logic        flag;
    logic        fin;
    logic [9:0]  result;
    logic [9:0]  data;
    logic        done;
    logic        pass;
    logic        timeout;
    logic [10:0] wrong_cnt;
    logic [10:0] get_cnt;

    logic        t_go;
    logic        t_start;
    logic [9:0]  t_data;
    logic        t_done;
    logic        t_pass;
    logic        t_timeout;
    logic [10:0] t_wrong;
    logic [10:0] t_get;

    int          total;
    int          bad;
    logic [10:0] m_mem [1024];
    logic [9:0]  m_ans;
    int          m_wrong;
    int          m_get;
    logic [31:0] exp_q [$];

    bon_pattern_server u_dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_load_en   (load_en),
        .i_load_addr (load_addr),
        .i_load_data (load_data),
        .i_ans_en    (ans_en),
        .i_ans_data  (ans_data),
        .i_go        (go),
        .o_start     (start),
        .i_en        (en),
        .i_addr      (addr),
        .i_flag      (flag),
        .i_fin       (fin),
        .i_result    (result),
        .o_data      (data),
        .o_done      (done),
        .o_pass      (pass),
        .o_timeout   (timeout),
        .o_wrong_cnt (wrong_cnt),
        .o_get_cnt   (get_cnt)
    );

    bon_pattern_server #(.TMO_W(4)) u_tmo (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_load_en   (1'b0),
        .i_load_addr (10'd0),
        .i_load_data (11'd0),
        .i_ans_en    (1'b0),
        .i_ans_data  (10'd0),
        .i_go        (t_go),
        .o_start     (t_start),
        .i_en        (1'b0),
        .i_addr      (10'd0),
        .i_flag      (1'b0),
        .i_fin       (1'b0),
        .i_result    (10'd0),
        .o_data      (t_data),
        .o_done      (t_done),
        .o_pass      (t_pass),
        .o_timeout   (t_timeout),
        .o_wrong_cnt (t_wrong),
        .o_get_cnt   (t_get)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input int a, input logic [10:0] d);
        load_en = 1'b1; load_addr = 10'(a); load_data = d;
        m_mem[a] = d;
        cyc();
        load_en = 1'b0;
    endtask

    task automatic start_run();
        go = 1'b1;
        cyc();
        go = 1'b0;
        m_wrong = 0;
        m_get = 0;
        chk("start_on_go", 32'(start), 32'd1);
    endtask

    // One requester access: expected word queued on drive, popped mid-cycle
    task automatic rd(input int a, input logic f, input logic fn, input logic [9:0] res);
        logic [10:0] e;
        en = 1'b1; addr = 10'(a); flag = f; fin = fn; result = res;
        e = m_mem[a];
        exp_q.push_back(32'(e[10:1]));
        if (f != e[0]) m_wrong++;
        else if (f) m_get++;
        #3;
        chk("data", 32'(data), exp_q.pop_front());
        cyc();
        en = 1'b0; fin = 1'b0; flag = 1'b0;
    endtask

    task automatic verdict(input string tag, input logic [9:0] res);
        logic exp_pass;
        exp_pass = (res == m_ans) && (m_wrong == 0);
        chk({tag, "_done"},  32'(done),      32'd1);
        chk({tag, "_start"}, 32'(start),     32'd0);
        chk({tag, "_tmo"},   32'(timeout),   32'd0);
        chk({tag, "_wrong"}, 32'(wrong_cnt), 32'(m_wrong));
        chk({tag, "_get"},   32'(get_cnt),   32'(m_get));
        chk({tag, "_pass"},  32'(pass),      32'(exp_pass));
    endtask

    initial begin
        int waited;
        total = 0; bad = 0;
        rst = 1'b0; load_en = 1'b0; load_addr = '0; load_data = '0;
        ans_en = 1'b0; ans_data = '0; go = 1'b0; t_go = 1'b0;
        en = 1'b0; addr = '0; flag = 1'b0; fin = 1'b0; result = '0;
        m_ans = '0; m_wrong = 0; m_get = 0;
        cyc(); cyc();
        chk("rst_start",   32'(start),     32'd0);
        chk("rst_done",    32'(done),      32'd0);
        chk("rst_pass",    32'(pass),      32'd0);
        chk("rst_timeout", 32'(timeout),   32'd0);
        chk("rst_wrong",   32'(wrong_cnt), 32'd0);
        chk("rst_get",     32'(get_cnt),   32'd0);
        chk("rst_t_done",  32'(t_done),    32'd0);
        rst = 1'b1;

        // Full sweep, all expected flags 0, correct result
        for (int i = 0; i < 1024; i++) begin
            load(i, {10'((i * 37 + 3) % 1024), 1'b0});
        end
        ans_en = 1'b1; ans_data = 10'd5;
        cyc();
        ans_en = 1'b0; m_ans = 10'd5;
        en = 1'b1; addr = 10'd3;
        #3;
        chk("idle_data_zero", 32'(data), 32'd0);
        cyc();
        en = 1'b0;
        start_run();
        chk("run_done_low", 32'(done), 32'd0);
        #3;
        chk("run_noen_data", 32'(data), 32'd0);
        cyc();
        for (int i = 0; i < 1024; i++) begin
            rd(i, 1'b0, i == 1023, 10'd5);
        end
        verdict("t1", 10'd5);
        chk("t1_pass_lit", 32'(pass), 32'd1);

        // Correct flag hit then a wrong flag
        load(17, {10'h2A, 1'b1});
        start_run();
        rd(17, 1'b1, 1'b0, 10'd0);
        chk("t2_get1", 32'(get_cnt), 32'd1);
        rd(18, 1'b1, 1'b0, 10'd0);
        chk("t2_wrong1", 32'(wrong_cnt), 32'd1);
        rd(0, 1'b0, 1'b1, 10'd5);
        verdict("t2", 10'd5);

        // Mismatch on the fin cycle at the top address
        start_run();
        rd(1023, 1'b1, 1'b1, 10'd5);
        verdict("t3", 10'd5);
        chk("t3_wrong_lit", 32'(wrong_cnt), 32'd1);

        // Wrong final result
        start_run();
        rd(5, 1'b0, 1'b1, 10'd6);
        verdict("t4", 10'd6);

        // Load ignored during RUN, then reset mid-run and rerun
        start_run();
        rd(17, 1'b1, 1'b0, 10'd0);
        load_en = 1'b1; load_addr = 10'd17; load_data = 11'd0;
        cyc();
        load_en = 1'b0;
        rst = 1'b0;
        cyc();
        rst = 1'b1;
        chk("t6_rst_start", 32'(start),   32'd0);
        chk("t6_rst_done",  32'(done),    32'd0);
        chk("t6_rst_get",   32'(get_cnt), 32'd0);
        m_ans = 10'd0;
        ans_en = 1'b1; ans_data = 10'd5;
        cyc();
        ans_en = 1'b0; m_ans = 10'd5;
        start_run();
        rd(17, 1'b1, 1'b0, 10'd0);
        rd(0, 1'b0, 1'b1, 10'd5);
        verdict("t6", 10'd5);
        chk("t6_pass_lit", 32'(pass), 32'd1);

        // Timeout instance never sees fin
        t_go = 1'b1;
        cyc();
        t_go = 1'b0;
        chk("t5_start", 32'(t_start), 32'd1);
        repeat (13) cyc();
        chk("t5_still_run", 32'(t_start), 32'd1);
        chk("t5_not_done",  32'(t_done),  32'd0);
        waited = 0;
        while (!t_done && waited < 40) begin
            cyc();
            waited++;
        end
        chk("t5_done",    32'(t_done),    32'd1);
        chk("t5_timeout", 32'(t_timeout), 32'd1);
        chk("t5_pass",    32'(t_pass),    32'd0);
        chk("t5_start_lo", 32'(t_start),  32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
